// File: rtl/pc_gen_pkg.sv
// Shared types, constants and address helpers for the fetch-stage PC generator.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } pc_state_e;

    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;
    localparam logic RstEnable   = 1'b0;

    // Clears the low log2(inst_bytes) bits; inst_bytes must be a power of two.
    function automatic logic [63:0] align_addr(input logic [63:0] addr,
                                               input int unsigned inst_bytes);
        return addr & ~(64'(inst_bytes) - 64'd1);
    endfunction

    function automatic logic addr_misaligned(input logic [63:0] addr,
                                             input int unsigned inst_bytes);
        return (addr & (64'(inst_bytes) - 64'd1)) != 64'd0;
    endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry buffer holding a branch target that arrived while the pipeline was stalled.
module pc_redirect_buf
    import pc_gen_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              capture_i,
    input  logic [ADDR_W-1:0] target_i,
    input  logic              clear_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] target_o
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] target_q, target_d;

    // Clear wins over capture so a flush discards a same-cycle branch.
    always_comb begin
        valid_d  = valid_q;
        target_d = target_q;
        if (clear_i) begin
            valid_d  = 1'b0;
            target_d = '0;
        end else if (capture_i) begin
            valid_d  = 1'b1;
            target_d = target_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (rst_ni == RstEnable) begin
            valid_q  <= 1'b0;
            target_q <= '0;
        end else begin
            valid_q  <= valid_d;
            target_q <= target_d;
        end
    end

    assign valid_o  = valid_q;
    assign target_o = target_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator with stall, branch redirect (buffered across stalls) and flush.
// Define PC_MISALIGN_CHECK_EN to add the registered pc_misalign_o flag.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 32,
    parameter int unsigned       INST_BYTES   = 4,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              stall_i,
    input  logic              br_valid_i,
    input  logic [ADDR_W-1:0] br_target_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              ce_o,
    output logic              redirect_pend_o
`ifdef PC_MISALIGN_CHECK_EN
    ,
    output logic              pc_misalign_o
`endif
);

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              load;
    logic [ADDR_W-1:0] load_src;
    logic              buf_capture, buf_clear, buf_valid;
    logic [ADDR_W-1:0] buf_target;

    pc_redirect_buf #(
        .ADDR_W (ADDR_W)
    ) u_redirect_buf (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .capture_i (buf_capture),
        .target_i  (br_target_i),
        .clear_i   (buf_clear),
        .valid_o   (buf_valid),
        .target_o  (buf_target)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        load        = 1'b0;
        load_src    = pc_q;
        buf_capture = 1'b0;
        buf_clear   = 1'b0;
        unique case (state_q)
            S_OFF: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (flush_i) begin
                    load      = 1'b1;
                    load_src  = flush_pc_i;
                    buf_clear = 1'b1;
                end else if (stall_i) begin
                    if (br_valid_i) begin
                        buf_capture = 1'b1;
                        state_d     = S_HOLD;
                    end
                end else if (br_valid_i) begin
                    load     = 1'b1;
                    load_src = br_target_i;
                end else begin
                    pc_d = pc_q + ADDR_W'(INST_BYTES);
                end
            end
            S_HOLD: begin
                if (flush_i) begin
                    load      = 1'b1;
                    load_src  = flush_pc_i;
                    buf_clear = 1'b1;
                    state_d   = S_RUN;
                end else if (stall_i) begin
                    buf_capture = br_valid_i;
                end else begin
                    // A fresh branch on the release edge supersedes the buffered one.
                    load      = 1'b1;
                    load_src  = br_valid_i ? br_target_i : buf_target;
                    buf_clear = 1'b1;
                    state_d   = S_RUN;
                end
            end
            default: begin
                state_d = S_OFF;
            end
        endcase
        if (load) begin
            pc_d = ADDR_W'(align_addr(64'(load_src), INST_BYTES));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (rst_ni == RstEnable) begin
            state_q <= S_OFF;
            pc_q    <= RESET_VECTOR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef PC_MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    assign misalign_d = load && addr_misaligned(64'(load_src), INST_BYTES);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (rst_ni == RstEnable) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign pc_misalign_o = misalign_q;
`endif

    assign pc_o            = pc_q;
    assign ce_o            = (state_q == S_OFF) ? ChipDisable : ChipEnable;
    assign redirect_pend_o = buf_valid;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a 32-bit default instance and a 16-bit instance for wrap checks.
module tb_pc_gen;

    typedef struct packed {
        logic [31:0] pc;
        logic        pend;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst32_n, rst16_n;
    logic        stall, br_valid, flush;
    logic [31:0] br_target, flush_pc;

    logic [31:0] pc32;
    logic [15:0] pc16;
    logic        ce32, ce16, pend32, pend16;
    logic        mis32, mis16;

    exp_t q32[$];
    exp_t q16[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pc_gen u_dut32 (
        .clk_i           (clk),
        .rst_ni          (rst32_n),
        .stall_i         (stall),
        .br_valid_i      (br_valid),
        .br_target_i     (br_target),
        .flush_i         (flush),
        .flush_pc_i      (flush_pc),
        .pc_o            (pc32),
        .ce_o            (ce32),
        .redirect_pend_o (pend32)
`ifdef PC_MISALIGN_CHECK_EN
        ,
        .pc_misalign_o   (mis32)
`endif
    );

    pc_gen #(
        .ADDR_W       (16),
        .INST_BYTES   (4),
        .RESET_VECTOR (16'h0000)
    ) u_dut16 (
        .clk_i           (clk),
        .rst_ni          (rst16_n),
        .stall_i         (stall),
        .br_valid_i      (br_valid),
        .br_target_i     (br_target[15:0]),
        .flush_i         (flush),
        .flush_pc_i      (flush_pc[15:0]),
        .pc_o            (pc16),
        .ce_o            (ce16),
        .redirect_pend_o (pend16)
`ifdef PC_MISALIGN_CHECK_EN
        ,
        .pc_misalign_o   (mis16)
`endif
    );

`ifndef PC_MISALIGN_CHECK_EN
    assign mis32 = 1'b0;
    assign mis16 = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Called just after a falling edge; expectation is what the DUT shows after the next rise.
    task automatic step(input logic sel16, input logic st, input logic bv,
                        input logic [31:0] bt, input logic fl, input logic [31:0] fp,
                        input logic [31:0] epc, input logic epend, input logic emis);
        exp_t e;
        stall     = st;
        br_valid  = bv;
        br_target = bt;
        flush     = fl;
        flush_pc  = fp;
        e.pc   = epc;
        e.pend = epend;
        e.mis  = emis;
        if (sel16) q16.push_back(e);
        else       q32.push_back(e);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (ce32) begin
            if (q32.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL out32_unexpected: pc 0x%08h with no expectation", pc32);
            end else begin
                e = q32.pop_front();
                chk("pc32", pc32, e.pc);
                chk("pend32", {31'd0, pend32}, {31'd0, e.pend});
`ifdef PC_MISALIGN_CHECK_EN
                chk("mis32", {31'd0, mis32}, {31'd0, e.mis});
`endif
            end
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (ce16) begin
            if (q16.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL out16_unexpected: pc 0x%04h with no expectation", pc16);
            end else begin
                e = q16.pop_front();
                chk("pc16", {16'd0, pc16}, e.pc);
                chk("pend16", {31'd0, pend16}, {31'd0, e.pend});
`ifdef PC_MISALIGN_CHECK_EN
                chk("mis16", {31'd0, mis16}, {31'd0, e.mis});
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst32_n = 1'b0;
        rst16_n = 1'b0;
        stall = 1'b0; br_valid = 1'b0; flush = 1'b0;
        br_target = '0; flush_pc = '0;
        #2;
        chk("rst_ce32", {31'd0, ce32}, 32'd0);
        chk("rst_pc32", pc32, 32'h0);
        chk("rst_pend32", {31'd0, pend32}, 32'd0);
        chk("rst_ce16", {31'd0, ce16}, 32'd0);

        @(negedge clk);
        rst32_n = 1'b1;
        //   sel st  bv  target         fl  flush_pc       exp_pc         pend mis
        step(0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 0, 0);
        step(0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0004, 0, 0);
        step(0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0008, 0, 0);
        step(0, 0, 1, 32'h100,      0, 32'h0,        32'h0000_0100, 0, 0);
        step(0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0104, 0, 0);
        // stall with a branch buffered, released after three cycles
        step(0, 1, 1, 32'h200,      0, 32'h0,        32'h0000_0104, 1, 0);
        step(0, 1, 0, 32'h0,        0, 32'h0,        32'h0000_0104, 1, 0);
        step(0, 1, 0, 32'h0,        0, 32'h0,        32'h0000_0104, 1, 0);
        step(0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0200, 0, 0);
        step(0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0204, 0, 0);
        // flush during stall discards the buffered target
        step(0, 1, 1, 32'h200,      0, 32'h0,        32'h0000_0204, 1, 0);
        step(0, 1, 0, 32'h0,        1, 32'h8000_0180, 32'h8000_0180, 0, 0);
        step(0, 1, 0, 32'h0,        0, 32'h0,        32'h8000_0180, 0, 0);
        step(0, 0, 0, 32'h0,        0, 32'h0,        32'h8000_0184, 0, 0);
        // last buffered target wins; release-edge branch beats the buffer
        step(0, 1, 1, 32'h400,      0, 32'h0,        32'h8000_0184, 1, 0);
        step(0, 1, 1, 32'h500,      0, 32'h0,        32'h8000_0184, 1, 0);
        step(0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0500, 0, 0);
        step(0, 1, 1, 32'h600,      0, 32'h0,        32'h0000_0500, 1, 0);
        step(0, 0, 1, 32'h700,      0, 32'h0,        32'h0000_0700, 0, 0);
        // misaligned targets are forced to alignment
        step(0, 0, 1, 32'h1002,     0, 32'h0,        32'h0000_1000, 0, 1);
        step(0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_1004, 0, 0);
        step(0, 0, 0, 32'h0,        1, 32'h2003,     32'h0000_2000, 0, 1);
        step(0, 1, 1, 32'h900,      0, 32'h0,        32'h0000_2000, 1, 0);
        // asynchronous reset while a redirect is pending
        #2;
        rst32_n = 1'b0;
        #1;
        chk("async_ce32", {31'd0, ce32}, 32'd0);
        chk("async_pc32", pc32, 32'h0);
        chk("async_pend32", {31'd0, pend32}, 32'd0);
        stall = 1'b0; br_valid = 1'b0;
        @(negedge clk);
        rst32_n = 1'b1;
        step(0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 0, 0);
        step(0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0004, 0, 0);
        rst32_n = 1'b0;

        // 16-bit instance: wrap and low-bit forcing
        rst16_n = 1'b1;
        step(1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 0, 0);
        step(1, 0, 0, 32'h0,        1, 32'hFFFC,     32'h0000_FFFC, 0, 0);
        step(1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 0, 0);
        step(1, 0, 1, 32'h0103,     0, 32'h0,        32'h0000_0100, 0, 1);
        step(1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0104, 0, 0);
        rst16_n = 1'b0;
        @(negedge clk);

        chk("q32_drained", q32.size(), 32'd0);
        chk("q16_drained", q16.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
